// File: rtl/rvv_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rvv_pkg
// Description : Shared definitions for the vector destination collector:
//               vsew encodings, lane-slot geometry, index width, the
//               collector state type and the element-width helper.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package rvv_pkg;

    // Element width codes carried on vsew
    localparam logic [2:0] c_VSEW_E8  = 3'd0;
    localparam logic [2:0] c_VSEW_E16 = 3'd1;
    localparam logic [2:0] c_VSEW_E32 = 3'd2;
    localparam logic [2:0] c_VSEW_E64 = 3'd3;

    // Result slot geometry on the lane bus
    localparam int c_SLOT_PITCH = 64;
    localparam int c_NUM_SLOTS  = 4;
    localparam int c_IDX_W      = 10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WB      = 2'd2
    } state_t;

    // log2 of the element width actually written per slot: the SEW is
    // clamped to the lane datapath width, so a 64-bit SEW on an 8-bit lane
    // still moves one byte per slot. Reserved vsew codes clamp the same way.
    function automatic logic [2:0] f_elem_log2(input logic [2:0] i_vsew,
                                               input int         i_lane_width);
        logic [3:0] sew_log2;
        sew_log2 = 4'd3 + {1'b0, i_vsew};
        if (int'(sew_log2) > i_lane_width) begin
            return 3'(i_lane_width);
        end
        return sew_log2[2:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/rvv_lane_scatter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rvv_lane_scatter
// Description : Combinational placement of one result slot into a VLEN-bit
//               register image. Produces the bit enables, the placed data,
//               the byte mask and a range/alignment error flag.
// Ports       : i_valid   - slot write request (already qualified)
//               i_idx     - destination bit offset
//               i_w_log2  - log2 of element width (3..6)
//               i_data    - 64-bit slot payload, low W bits used
//               o_bit_en  - bits written by this slot
//               o_bit_val - placed data, zero outside o_bit_en
//               o_byte_en - bytes written by this slot
//               o_err     - request was out of range or misaligned
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rvv_lane_scatter
    import rvv_pkg::*;
#(
    parameter int VLEN = 128
) (
    input  logic                    i_valid,
    input  logic [c_IDX_W-1:0]      i_idx,
    input  logic [2:0]              i_w_log2,
    input  logic [c_SLOT_PITCH-1:0] i_data,
    output logic [VLEN-1:0]         o_bit_en,
    output logic [VLEN-1:0]         o_bit_val,
    output logic [VLEN/8-1:0]       o_byte_en,
    output logic                    o_err
);

    localparam int         c_EXT    = VLEN + c_SLOT_PITCH;
    localparam int         c_BEXT   = VLEN/8 + 8;
    localparam logic [11:0] c_VLEN12 = 12'(VLEN);

    logic [6:0]              w_w;
    logic [c_SLOT_PITCH-1:0] w_elem_mask;
    logic [7:0]              w_byte_mask;
    logic [11:0]             w_end;
    logic [c_IDX_W-1:0]      w_align_mask;
    logic                    w_oor;
    logic                    w_misal;
    logic                    w_ok;
    logic [c_EXT-1:0]        w_val_ext;
    logic [c_EXT-1:0]        w_en_ext;
    logic [c_BEXT-1:0]       w_byte_ext;
    logic                    w_unused_hi;

    assign w_w = 7'd1 << i_w_log2;

    // A shift by the full 64 yields zero, so W=64 gives an all-ones mask
    assign w_elem_mask = ~({c_SLOT_PITCH{1'b1}} << w_w);
    assign w_byte_mask = ~(8'hFF << w_w[6:3]);

    // 12-bit sum: idx (max 1023) + W (max 64) cannot wrap
    assign w_end        = {2'b00, i_idx} + {5'd0, w_w};
    assign w_align_mask = {3'b000, w_w} - 10'd1;
    assign w_oor        = (w_end > c_VLEN12);
    assign w_misal      = |(i_idx & w_align_mask);
    assign w_ok         = i_valid & ~w_oor & ~w_misal;
    assign o_err        = i_valid & (w_oor | w_misal);

    // Widened by one slot so a shift never loses bits; for an in-range
    // write everything above VLEN is zero and can be discarded.
    assign w_val_ext  = {{VLEN{1'b0}}, i_data & w_elem_mask} << i_idx;
    assign w_en_ext   = {{VLEN{1'b0}}, w_elem_mask} << i_idx;
    assign w_byte_ext = {{(VLEN/8){1'b0}}, w_byte_mask} << i_idx[c_IDX_W-1:3];

    assign o_bit_val = w_ok ? w_val_ext[VLEN-1:0]    : '0;
    assign o_bit_en  = w_ok ? w_en_ext[VLEN-1:0]     : '0;
    assign o_byte_en = w_ok ? w_byte_ext[VLEN/8-1:0] : '0;

    assign w_unused_hi = ^{w_val_ext[c_EXT-1:VLEN], w_en_ext[c_EXT-1:VLEN],
                           w_byte_ext[c_BEXT-1:VLEN/8]};

endmodule
`default_nettype wire

// File: rtl/rvv_vd_collector.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : rvv_vd_collector
// Description : Gathers per-lane ALU results into one VLEN-bit destination
//               register image plus byte write mask, and hands it to the
//               register file with a valid/ready writeback handshake.
// Ports       : clk, resetn (sync, active-high)
//               start/vsew      - begin a collection, capture element width
//               lane_data/idx/valid - four result slots from the ALU
//               alu_done        - last results are on the lane bus
//               vd_out/wr_mask/vd_valid/vd_ready - writeback interface
//               busy/err        - status; err is sticky until next start
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module rvv_vd_collector
    import rvv_pkg::*;
#(
    parameter int VLEN       = 128,
    parameter int LANE_WIDTH = 3,
    parameter int NB_LANES   = 1
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                start,
    input  logic [2:0]                          vsew,
    input  logic [c_NUM_SLOTS*c_SLOT_PITCH-1:0] lane_data,
    input  logic [c_NUM_SLOTS*c_IDX_W-1:0]      lane_idx,
    input  logic [c_NUM_SLOTS-1:0]              lane_valid,
    input  logic                                alu_done,
    output logic [VLEN-1:0]                     vd_out,
    output logic [VLEN/8-1:0]                   wr_mask,
    output logic                                vd_valid,
    input  logic                                vd_ready,
    output logic                                busy,
    output logic                                err
);

    localparam int c_ACTIVE = 1 << NB_LANES;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [VLEN-1:0]     r_vd;
    logic [VLEN/8-1:0]   r_mask;
    logic                r_err;
    logic [2:0]          r_w_log2;

    logic                w_collect;
    logic [VLEN-1:0]     w_bit_en  [c_NUM_SLOTS];
    logic [VLEN-1:0]     w_bit_val [c_NUM_SLOTS];
    logic [VLEN/8-1:0]   w_byte_en [c_NUM_SLOTS];
    logic                w_slot_err[c_NUM_SLOTS];
    logic [VLEN-1:0]     w_vd_nxt;
    logic [VLEN/8-1:0]   w_mask_set;
    logic                w_err_any;

    // Lane writes (and their range errors) only count while collecting
    assign w_collect = (r_state == COLLECT);

    for (genvar gk = 0; gk < c_NUM_SLOTS; gk++) begin : g_slot
        localparam bit c_EN = (gk < c_ACTIVE);

        rvv_lane_scatter #(
            .VLEN (VLEN)
        ) u_scatter (
            .i_valid   (lane_valid[gk] & c_EN & w_collect),
            .i_idx     (lane_idx[gk*c_IDX_W +: c_IDX_W]),
            .i_w_log2  (r_w_log2),
            .i_data    (lane_data[gk*c_SLOT_PITCH +: c_SLOT_PITCH]),
            .o_bit_en  (w_bit_en[gk]),
            .o_bit_val (w_bit_val[gk]),
            .o_byte_en (w_byte_en[gk]),
            .o_err     (w_slot_err[gk])
        );
    end

    // Merge in ascending slot order so the highest slot lands last and wins
    always_comb begin
        w_vd_nxt   = r_vd;
        w_mask_set = '0;
        w_err_any  = 1'b0;
        for (int k = 0; k < c_NUM_SLOTS; k++) begin
            w_vd_nxt   = (w_vd_nxt & ~w_bit_en[k]) | w_bit_val[k];
            w_mask_set = w_mask_set | w_byte_en[k];
            w_err_any  = w_err_any | w_slot_err[k];
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start)    w_state_nxt = COLLECT;
            COLLECT: if (alu_done) w_state_nxt = WB;
            WB:      if (vd_ready) w_state_nxt = IDLE;
            default:               w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (resetn) begin
            r_vd     <= '0;
            r_mask   <= '0;
            r_err    <= 1'b0;
            r_w_log2 <= 3'd3;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_vd     <= '0;
                        r_mask   <= '0;
                        r_err    <= 1'b0;
                        r_w_log2 <= f_elem_log2(vsew, LANE_WIDTH);
                    end
                end
                COLLECT: begin
                    r_vd   <= w_vd_nxt;
                    r_mask <= r_mask | w_mask_set;
                    r_err  <= r_err | w_err_any;
                end
                default: begin
                    // WB: image is frozen until the register file takes it
                end
            endcase
        end
    end

    assign vd_out   = r_vd;
    assign wr_mask  = r_mask;
    assign err      = r_err;
    assign vd_valid = (r_state == WB);
    assign busy     = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rvv_vd_collector.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_rvv_vd_collector
// Description : Directed self-checking bench for rvv_vd_collector. A second
//               instance with a 16-bit lane datapath covers W=16 range checks.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_rvv_vd_collector;

    localparam int VLEN = 128;

    logic         clk = 1'b0;
    logic         resetn;
    logic         start;
    logic [2:0]   vsew;
    logic [255:0] lane_data;
    logic [39:0]  lane_idx;
    logic [3:0]   lane_valid;
    logic         alu_done;
    logic         vd_ready;

    logic [VLEN-1:0]   vd_out,   vd_out2;
    logic [VLEN/8-1:0] wr_mask,  wr_mask2;
    logic              vd_valid, vd_valid2;
    logic              busy,     busy2;
    logic              err,      err2;

    int errors = 0;
    int checks = 0;

    logic [127:0] t1;
    logic [127:0] t2;

    always #5 clk = ~clk;

    rvv_vd_collector #(.VLEN(VLEN), .LANE_WIDTH(3), .NB_LANES(1)) dut (
        .clk(clk), .resetn(resetn), .start(start), .vsew(vsew),
        .lane_data(lane_data), .lane_idx(lane_idx), .lane_valid(lane_valid),
        .alu_done(alu_done), .vd_out(vd_out), .wr_mask(wr_mask),
        .vd_valid(vd_valid), .vd_ready(vd_ready), .busy(busy), .err(err)
    );

    rvv_vd_collector #(.VLEN(VLEN), .LANE_WIDTH(4), .NB_LANES(1)) dut_w16 (
        .clk(clk), .resetn(resetn), .start(start), .vsew(vsew),
        .lane_data(lane_data), .lane_idx(lane_idx), .lane_valid(lane_valid),
        .alu_done(alu_done), .vd_out(vd_out2), .wr_mask(wr_mask2),
        .vd_valid(vd_valid2), .vd_ready(vd_ready), .busy(busy2), .err(err2)
    );

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_slot(input int k, input logic [9:0] idx, input logic [63:0] data);
        lane_idx[10*k +: 10]  = idx;
        lane_data[64*k +: 64] = data;
        lane_valid[k]         = 1'b1;
    endtask

    initial begin
        t1 = 128'h3232eeeed0231467d02314673232eeee;
        t2 = 128'h001E001C001A00180016001400120010;
        resetn = 1'b1; start = 1'b0; vsew = 3'd0; lane_data = '0; lane_idx = '0;
        lane_valid = '0; alu_done = 1'b0; vd_ready = 1'b0;
        tick(); tick();
        chk("rst_vd_out",   vd_out,   128'h0);
        chk("rst_wr_mask",  wr_mask,  128'h0);
        chk("rst_vd_valid", vd_valid, 128'h0);
        chk("rst_busy",     busy,     128'h0);
        chk("rst_err",      err,      128'h0);
        resetn = 1'b0;
        tick();

        // Full-register byte assembly, two lanes per cycle, junk above W
        vsew = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy_collect", busy, 128'h1);
        for (int c = 0; c < 8; c++) begin
            lane_valid = '0;
            set_slot(0, 10'(16*c),     {56'hFFFFFFFFFFFFFF, t1[16*c +: 8]});
            set_slot(1, 10'(16*c + 8), {56'hFFFFFFFFFFFFFF, t1[16*c + 8 +: 8]});
            alu_done = (c == 7);
            tick();
            if (c == 3) begin
                chk("t1_half_vd",   vd_out,  128'hd02314673232eeee);
                chk("t1_half_mask", wr_mask, 128'h00FF);
                chk("t1_half_valid", vd_valid, 128'h0);
            end
        end
        lane_valid = '0; alu_done = 1'b0;
        chk("t1_vd_valid", vd_valid, 128'h1);
        chk("t1_vd_out",   vd_out,   128'h3232eeeed0231467d02314673232eeee);
        chk("t1_wr_mask",  wr_mask,  128'hFFFF);
        chk("t1_err",      err,      128'h0);
        vd_ready = 1'b1;
        tick();
        vd_ready = 1'b0;
        chk("t1_post_valid", vd_valid, 128'h0);
        chk("t1_post_busy",  busy,     128'h0);
        chk("t1_post_hold",  vd_out,   128'h3232eeeed0231467d02314673232eeee);

        // vsew=3 clamped to 8-bit lanes; even bytes only; slot 2 is unused
        vsew = 3'd3; start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_clear_vd",   vd_out,  128'h0);
        chk("t2_clear_mask", wr_mask, 128'h0);
        for (int c = 0; c < 4; c++) begin
            lane_valid = '0;
            set_slot(0, 10'(32*c),      {56'hFFFFFFFFFFFFFF, 8'(8'h10 + 4*c)});
            set_slot(1, 10'(32*c + 16), {56'hFFFFFFFFFFFFFF, 8'(8'h12 + 4*c)});
            set_slot(2, 10'(32*c + 8),  64'hFF);
            alu_done = (c == 3);
            tick();
        end
        lane_valid = '0; alu_done = 1'b0;
        chk("t2_vd_valid", vd_valid, 128'h1);
        chk("t2_wr_mask",  wr_mask,  128'h5555);
        chk("t2_vd_out",   vd_out,   128'h001E001C001A00180016001400120010);
        chk("t2_err",      err,      128'h0);

        // WB hold with vd_ready low while other inputs toggle
        for (int i = 0; i < 5; i++) begin
            lane_valid = '0;
            if (i % 2 == 0) set_slot(0, 10'd8, 64'hFF);
            start    = (i % 2 == 1);
            alu_done = (i % 2 == 0);
            vd_ready = 1'b0;
            tick();
            chk("wb_hold_valid", vd_valid, 128'h1);
            chk("wb_hold_vd",    vd_out,   t2);
            chk("wb_hold_mask",  wr_mask,  128'h5555);
            chk("wb_hold_busy",  busy,     128'h1);
        end
        lane_valid = '0; alu_done = 1'b0;
        vd_ready = 1'b1; start = 1'b1;
        tick();
        vd_ready = 1'b0; start = 1'b0;
        chk("wb_exit_valid", vd_valid, 128'h0);
        chk("wb_exit_busy",  busy,     128'h0);
        tick();
        chk("wb_start_ignored", busy,  128'h0);
        chk("idle_hold_vd",     vd_out, 128'h001E001C001A00180016001400120010);

        // Two slots on the same byte, then a later overwrite
        vsew = 3'd0; start = 1'b1;
        tick();
        start = 1'b0;
        lane_valid = '0;
        set_slot(0, 10'd16, 64'hAA);
        set_slot(1, 10'd16, 64'h55);
        tick();
        chk("ovl_vd",   vd_out,  128'h550000);
        chk("ovl_mask", wr_mask, 128'h0004);
        lane_valid = '0;
        set_slot(0, 10'd16, 64'h77);
        alu_done = 1'b1;
        tick();
        lane_valid = '0; alu_done = 1'b0;
        chk("ovr_vd",    vd_out,   128'h770000);
        chk("ovr_valid", vd_valid, 128'h1);
        vd_ready = 1'b1;
        tick();
        vd_ready = 1'b0;

        // Out-of-range / misaligned index on the 16-bit lane instance
        vsew = 3'd1; start = 1'b1;
        tick();
        start = 1'b0;
        lane_valid = '0;
        set_slot(0, 10'd0, 64'hFFFFFFFFFFFFBEEF);
        tick();
        chk("w16_vd",    vd_out2,  128'hBEEF);
        chk("w16_mask",  wr_mask2, 128'h0003);
        chk("w16_err0",  err2,     128'h0);
        chk("w8_vd",     vd_out,   128'hEF);
        chk("w8_mask",   wr_mask,  128'h0001);
        lane_valid = '0;
        set_slot(0, 10'd124, 64'h1234);
        tick();
        lane_valid = '0;
        chk("w16_oor_err",  err2,     128'h1);
        chk("w16_oor_vd",   vd_out2,  128'hBEEF);
        chk("w16_oor_mask", wr_mask2, 128'h0003);
        chk("w8_mis_err",   err,      128'h1);
        chk("w8_mis_vd",    vd_out,   128'hEF);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("w16_err_wb", err2, 128'h1);
        vd_ready = 1'b1;
        tick();
        vd_ready = 1'b0;
        chk("w16_err_idle", err2, 128'h1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_clr_err2", err2,    128'h0);
        chk("start_clr_err",  err,     128'h0);
        chk("start_clr_vd2",  vd_out2, 128'h0);

        // Reset in the middle of a collection
        vsew = 3'd0;
        lane_valid = '0;
        set_slot(0, 10'd0, 64'h11);
        tick();
        lane_valid = '0;
        chk("pre_rst_vd", vd_out, 128'h11);
        resetn = 1'b1;
        tick();
        resetn = 1'b0;
        chk("mid_rst_vd",    vd_out,   128'h0);
        chk("mid_rst_mask",  wr_mask,  128'h0);
        chk("mid_rst_busy",  busy,     128'h0);
        chk("mid_rst_valid", vd_valid, 128'h0);
        chk("mid_rst_err",   err,      128'h0);
        alu_done = 1'b1;
        tick();
        alu_done = 1'b0;
        chk("rst_done_valid", vd_valid, 128'h0);
        chk("rst_done_busy",  busy,     128'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rvv_vd_collector.md
# rvv_vd_collector

Result-side counterpart of `rvv_alu_wrapper`: consumes the per-lane result stream (`vd`, `regi`, `res`, `done_out`) and assembles the scattered lane elements into one VLEN-bit destination register image. It sits between the vector ALU and the vector register file write port. It presents the assembled register and byte write mask with a valid/ready writeback handshake once the ALU signals completion.

## Interface
- `VLEN`, 128: vector register length in bits; must be ≤ 1024, since indices are 10 bits.
- `LANE_WIDTH`, 3: log2 of lane datapath width in bits (3..6).
- `NB_LANES`, 1: log2 of lanes in use (0..2); slots at or above `1<<NB_LANES` are ignored.

Ports:
- `clk` in 1: one clock.
- `resetn` in 1: reset is synchronous and active-high (name kept per codebase; asserted = 1).
- `start` in 1: one-cycle pulse that begins a new collection; honoured only in IDLE.
- `vsew` in 3: element width code, captured at `start` (0=8b, 1=16b, 2=32b, 3=64b).
- `lane_data` in 256: four 64-bit result slots; slot k = `[64k +: 64]`.
- `lane_idx` in 40: four 10-bit destination bit offsets; slot k = `[10k +: 10]`.
- `lane_valid` in 4: per-slot write enable, matching the ALU `res`.
- `alu_done` in 1: the ALU has finished; results presented in the same cycle are final.
- `vd_out` out VLEN: assembled destination register.
- `wr_mask` out VLEN/8: bytes written since `start`.
- `vd_valid` out 1: writeback request.
- `vd_ready` in 1: the register file accepts writeback.
- `busy` out 1: high in COLLECT and WB.
- `err` out 1: sticky out-of-range index flag, cleared at `start`.

## Operation
- States:
  - IDLE: `start` → COLLECT. Captures `vsew`, clears `vd_out`, `wr_mask` and `err`.
  - COLLECT: writes lanes every cycle. `alu_done` → WB.
  - WB: `vd_valid`=1. `vd_ready` → IDLE.
- Element width W = min(8<<vsew, 1<<LANE_WIDTH) bits. For each slot k < (1<<NB_LANES) with `lane_valid[k]`:
  - Write `vd_out[lane_idx_k +: W]` = `lane_data[64k +: W]`.
  - Set the W/8 mask bits starting at `lane_idx_k/8`.
- Range checks:
  - If `lane_idx_k + W > VLEN`, the slot write is dropped and `err` is set.
  - `lane_idx_k` not a multiple of W is also dropped and sets `err`.
- Overlapping slot writes in one cycle: the higher slot index wins.
- A later cycle's write to the same bits overwrites the earlier value.
- `lane_valid` in IDLE or WB is ignored, with no write and no `err`.
- `start` in COLLECT or WB is ignored.
- `alu_done` in IDLE or WB is ignored.
- `vd_out`, `wr_mask` and `err` hold their values in WB and in IDLE after writeback, until the next `start`.

## Timing
- Reset values: state=IDLE, `vd_out`=0, `wr_mask`=0, `vd_valid`=0, `busy`=0, `err`=0.
- Reset has priority over every other input. Reset in COLLECT or WB aborts the collection, and no writeback occurs.
- A lane write sampled at edge N is visible on `vd_out` and `wr_mask` after edge N.
- `alu_done` sampled at edge N, together with that cycle's lane writes, gives `vd_valid`=1 after edge N. This is one cycle of latency.
- `vd_valid` stays high, and `vd_out` stays stable, until `vd_ready` is sampled high.
  - `vd_valid` drops after that edge.
  - If `vd_ready` is already high on the first WB cycle, the transfer completes in one cycle.
- `start` on the edge that leaves WB is ignored. The earliest new `start` is the first IDLE cycle.

## Structure
- Shared package `rvv_pkg` holds:
  - the vsew encodings;
  - the slot pitch (64) and slot count (4);
  - the index width (10);
  - the state enum {IDLE, COLLECT, WB}.
- Natural sub-module: `rvv_lane_scatter`, one instance per slot. It is combinational: from idx, W, data and VLEN it produces the bit-enable vector, the byte-mask vector and the range-error flag.
- The top module holds the FSM, the accumulator registers and the priority merge across slots.

## Test plan
- Default parameters, vsew=0, W=8. Over 8 cycles, two lanes per cycle write the bytes of `3232eeeed0231467d02314673232eeee`, then `alu_done`. Expected: one cycle later `vd_valid`=1, `vd_out` equals that value, `wr_mask`=16'hFFFF, `err`=0.
- vsew=3 with LANE_WIDTH=3, so W stays 8. Only even byte indices are written, plus `alu_done`. Expected: `wr_mask`=16'h5555, odd bytes are 0.
- Slot 0 and slot 1 both target idx 16, with data 8'hAA and 8'h55. Expected: byte 2 = 8'h55.
- idx=10'd124 with vsew=1 and LANE_WIDTH=4, so W=16. Expected: `err`=1, `vd_out` unchanged. The next `start` clears `err`.
- WB with `vd_ready`=0 held for 5 cycles while `lane_valid`/`alu_done`/`start` toggle. Expected: `vd_valid` stays 1, `vd_out` is stable, and the toggling inputs have no effect. `vd_ready`=1 then gives IDLE one cycle later.
- `resetn`=1 asserted mid-COLLECT. Expected: all outputs return to 0 on the next cycle, and a subsequent `alu_done` is ignored.
